// File: rtl/color_ctrl_pkg.sv
// Shared types and widths for the color-slot editing path.
package color_ctrl_pkg;

    localparam int COLOR_W           = 24;
    localparam int NIBBLE_W          = 4;
    localparam int NIBBLES_PER_COLOR = 6;

    typedef enum logic [2:0] {
        IDLE,
        START,
        COLLECT,
        WAIT_DONE,
        COMMIT
    } state_e;

endpackage

// File: rtl/inactivity_timer.sv
// Saturating up-counter; expired_o holds once the count reaches limit_i.
module inactivity_timer #(
    parameter int W = 20
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clear_i,
    input  logic         enable_i,
    input  logic [W-1:0] limit_i,
    output logic         expired_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q >= limit_i);

endmodule

// File: rtl/color_slot_sequencer.sv
// Drives one color_changer session per edit request and commits the
// assembled color into the selected slot of a flat slot register.
module color_slot_sequencer
    import color_ctrl_pkg::*;
#(
    parameter int                  NUM_SLOTS      = 4,
    parameter int                  SLOT_W         = 2,
    parameter int                  TIMER_W        = 20,
    parameter logic [TIMER_W-1:0]  TIMEOUT_CYCLES = 20'd1000000,
    parameter int                  DONE_WAIT      = 8,
    parameter logic [23:0]         DEFAULT_COLOR  = 24'hFFFFFF
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         edit_req,
    input  logic [SLOT_W-1:0]            slot_sel,
    input  logic                         key_valid,
    input  logic [3:0]                   key_value,
    input  logic                         cancel,
    output logic                         cc_switch,
    output logic                         cc_ready,
    output logic [3:0]                   cc_value,
    input  logic [23:0]                  cc_final_color,
    input  logic                         cc_done,
    output logic                         busy,
    output logic [SLOT_W-1:0]            active_slot,
    output logic [NUM_SLOTS*24-1:0]      slot_colors,
    output logic                         commit_pulse,
    output logic                         timeout_err
);

    state_e                         state_q, state_d;
    logic [2:0]                     nib_cnt_q, nib_cnt_d;
    logic [SLOT_W-1:0]              active_slot_q, active_slot_d;
    logic                           cc_ready_q, cc_ready_d;
    logic [NIBBLE_W-1:0]            cc_value_q, cc_value_d;
    logic [COLOR_W-1:0]             color_q, color_d;
    logic [NUM_SLOTS*COLOR_W-1:0]   slots_q, slots_d;

    logic                           tmr_clear;
    logic                           tmr_en;
    logic                           tmr_expired;
    logic [TIMER_W-1:0]             tmr_limit;

    inactivity_timer #(
        .W (TIMER_W)
    ) u_timer (
        .clk_i     (clk),
        .rst_i     (reset),
        .clear_i   (tmr_clear),
        .enable_i  (tmr_en),
        .limit_i   (tmr_limit),
        .expired_o (tmr_expired)
    );

    always_comb begin
        state_d       = state_q;
        nib_cnt_d     = nib_cnt_q;
        active_slot_d = active_slot_q;
        cc_ready_d    = 1'b0;
        cc_value_d    = cc_value_q;
        color_d       = color_q;
        slots_d       = slots_q;
        tmr_clear     = 1'b0;
        tmr_en        = 1'b0;
        tmr_limit     = TIMEOUT_CYCLES;
        cc_switch     = 1'b0;
        commit_pulse  = 1'b0;
        timeout_err   = 1'b0;

        case (state_q)
            IDLE: begin
                if (edit_req && (int'(slot_sel) < NUM_SLOTS)) begin
                    active_slot_d = slot_sel;
                    state_d       = START;
                end
            end
            START: begin
                cc_switch = 1'b1;
                tmr_clear = 1'b1;
                nib_cnt_d = '0;
                state_d   = cancel ? IDLE : COLLECT;
            end
            COLLECT: begin
                tmr_en = 1'b1;
                // Priority: cancel, then a fresh key, then inactivity.
                if (cancel) begin
                    state_d = IDLE;
                end else if (key_valid && (nib_cnt_q < 3'(NIBBLES_PER_COLOR))) begin
                    cc_ready_d = 1'b1;
                    cc_value_d = key_value;
                    nib_cnt_d  = nib_cnt_q + 3'd1;
                    tmr_clear  = 1'b1;
                    if (nib_cnt_q == 3'(NIBBLES_PER_COLOR - 1)) begin
                        state_d = WAIT_DONE;
                    end
                end else if (tmr_expired) begin
                    timeout_err = 1'b1;
                    state_d     = IDLE;
                end
            end
            WAIT_DONE: begin
                tmr_en    = 1'b1;
                tmr_limit = TIMER_W'(DONE_WAIT);
                if (cancel) begin
                    state_d = IDLE;
                end else if (cc_done) begin
                    color_d = cc_final_color;
                    state_d = COMMIT;
                end else if (tmr_expired) begin
                    timeout_err = 1'b1;
                    state_d     = IDLE;
                end
            end
            COMMIT: begin
                commit_pulse = 1'b1;
                slots_d[active_slot_q*COLOR_W +: COLOR_W] = color_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            nib_cnt_q     <= '0;
            active_slot_q <= '0;
            cc_ready_q    <= 1'b0;
            cc_value_q    <= '0;
            color_q       <= '0;
            slots_q       <= {NUM_SLOTS{DEFAULT_COLOR}};
        end else begin
            state_q       <= state_d;
            nib_cnt_q     <= nib_cnt_d;
            active_slot_q <= active_slot_d;
            cc_ready_q    <= cc_ready_d;
            cc_value_q    <= cc_value_d;
            color_q       <= color_d;
            slots_q       <= slots_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign active_slot = active_slot_q;
    assign cc_ready    = cc_ready_q;
    assign cc_value    = cc_value_q;
    assign slot_colors = slots_q;

endmodule
